// File: rtl/xgmii_tx_encoder.sv
// XGMII transmit encoder: frames a 64-bit valid/ready byte stream with /S/, /T/ and the inter-frame gap.
// Define XGMII_TX_FCS_EN to compute and append the Ethernet CRC-32 in hardware.
module xgmii_tx_encoder (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic [63:0] s_data,
  input  logic [7:0]  s_keep,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [31:0] tx_frames,
  output logic [15:0] tx_aborts
);

  localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  localparam logic [63:0] ERROR_WORD = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;

  typedef enum logic [2:0] {IDLE, PRE, DATA, FCS, TERM, IFG, ERR, DROP} state_t;

  state_t       state_q, state_d;
  logic [63:0]  txd_q, txd_d, spillTxd_q, spillTxd_d;
  logic [7:0]   txc_q, txc_d, spillTxc_q, spillTxc_d;
  logic         ready_q, ready_d, dropPend_q, dropPend_d;
  logic [1:0]   ifgLeft_q, ifgLeft_d, spillIfg_q, spillIfg_d;
  logic [31:0]  frames_q, frames_d;
  logic [15:0]  aborts_q, aborts_d;
  logic [3:0]   keepCnt, tpos;
  logic         keepOk;
  logic [127:0] dataExt, tailTxd;
  logic [15:0]  tailTxc;

  assign keepCnt = 4'($countones(s_keep));
  assign keepOk  = (s_keep != 8'h00) && ((s_keep & (s_keep + 8'd1)) == 8'h00);
  assign dataExt = {64'h0, s_data};

`ifdef XGMII_TX_FCS_EN
  logic [31:0] crc_q, crc_d, fcsVal;

  function automatic logic [31:0] crcBytes(input logic [31:0] crcIn, input logic [63:0] data,
                                           input logic [3:0] nBytes);
    logic [31:0] c;
    c = crcIn;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nBytes)) begin
        c = c ^ {24'h0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  assign fcsVal = ~crcBytes(crc_q, s_data, keepCnt);
  assign tpos   = keepCnt + 4'd4;

  always_comb begin
    crc_d = crc_q;
    if (state_q == IDLE) crc_d = 32'hFFFFFFFF;
    else if ((state_q == PRE || state_q == DATA) && s_valid && !s_last)
      crc_d = crcBytes(crc_q, s_data, 4'd8);
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) crc_q <= 32'hFFFFFFFF;
    else            crc_q <= crc_d;
  end
`else
  assign tpos = keepCnt;
`endif

  // Two-word view of the last beat: data, optional FCS, /T/, then idles; word 1 is the spill.
  always_comb begin
    tailTxd = '0;
    tailTxc = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(keepCnt)) begin
        tailTxd[8*i +: 8] = dataExt[8*i +: 8];
`ifdef XGMII_TX_FCS_EN
      end else if (i < int'(tpos)) begin
        tailTxd[8*i +: 8] = 8'(fcsVal >> (8 * (i - int'(keepCnt))));
`endif
      end else begin
        tailTxd[8*i +: 8] = (i == int'(tpos)) ? 8'hFD : 8'h07;
        tailTxc[i]        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    txd_d      = IDLE_WORD;
    txc_d      = 8'hFF;
    ready_d    = 1'b0;
    ifgLeft_d  = ifgLeft_q;
    spillTxd_d = spillTxd_q;
    spillTxc_d = spillTxc_q;
    spillIfg_d = spillIfg_q;
    dropPend_d = dropPend_q;
    frames_d   = frames_q;
    aborts_d   = aborts_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = PRE;
          txd_d   = START_WORD;
          txc_d   = 8'h01;
          ready_d = 1'b1;
        end
      end
      PRE, DATA: begin
        ready_d = 1'b1;
        if (!s_valid || (s_last && !keepOk)) begin
          state_d    = ERR;
          txd_d      = ERROR_WORD;
          ready_d    = 1'b0;
          dropPend_d = !s_valid;
        end else if (!s_last) begin
          state_d = DATA;
          txd_d   = s_data;
          txc_d   = 8'h00;
        end else begin
          ready_d = 1'b0;
          txd_d   = tailTxd[63:0];
          txc_d   = tailTxc[7:0];
          if (tpos < 4'd8) begin
            state_d   = IFG;
            frames_d  = frames_q + 32'd1;
            ifgLeft_d = (tpos <= 4'd3) ? 2'd1 : 2'd2;
          end else begin
            state_d    = (tpos == 4'd8) ? TERM : FCS;
            spillTxd_d = tailTxd[127:64];
            spillTxc_d = tailTxc[15:8];
            spillIfg_d = (tpos <= 4'd11) ? 2'd1 : 2'd2;
          end
        end
      end
      FCS, TERM: begin
        state_d   = IFG;
        txd_d     = spillTxd_q;
        txc_d     = spillTxc_q;
        frames_d  = frames_q + 32'd1;
        ifgLeft_d = spillIfg_q;
      end
      ERR: begin
        txd_d    = TERM_WORD;
        aborts_d = aborts_q + 16'd1;
        if (dropPend_q) begin
          state_d = DROP;
          ready_d = 1'b1;
        end else begin
          state_d   = IFG;
          ifgLeft_d = 2'd1;
        end
      end
      DROP: begin
        ready_d = 1'b1;
        if (s_valid && s_last) begin
          state_d   = IFG;
          ready_d   = 1'b0;
          ifgLeft_d = 2'd1;
        end
      end
      IFG: begin
        if (ifgLeft_q <= 2'd1) state_d = IDLE;
        else                   ifgLeft_d = ifgLeft_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      txd_q      <= IDLE_WORD;
      txc_q      <= 8'hFF;
      ready_q    <= 1'b0;
      ifgLeft_q  <= 2'd0;
      spillTxd_q <= IDLE_WORD;
      spillTxc_q <= 8'hFF;
      spillIfg_q <= 2'd0;
      dropPend_q <= 1'b0;
      frames_q   <= 32'd0;
      aborts_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      txc_q      <= txc_d;
      ready_q    <= ready_d;
      ifgLeft_q  <= ifgLeft_d;
      spillTxd_q <= spillTxd_d;
      spillTxc_q <= spillTxc_d;
      spillIfg_q <= spillIfg_d;
      dropPend_q <= dropPend_d;
      frames_q   <= frames_d;
      aborts_q   <= aborts_d;
    end
  end

  assign s_ready   = ready_q;
  assign xgmii_txd = txd_q;
  assign xgmii_txc = txc_q;
  assign tx_frames = frames_q;
  assign tx_aborts = aborts_q;

endmodule

// File: tb/tb_xgmii_tx_encoder.sv
// Directed self-checking bench for xgmii_tx_encoder; inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_xgmii_tx_encoder;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;

  logic        clk156 = 1'b0;
  logic        sys_rst_n;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [31:0] tx_frames;
  logic [15:0] tx_aborts;

  int assertCount = 0;
  int failCount   = 0;
  int expFrames   = 0;
  int expAborts   = 0;

  xgmii_tx_encoder dut (
    .clk156    (clk156),
    .sys_rst_n (sys_rst_n),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .xgmii_txd (xgmii_txd),
    .xgmii_txc (xgmii_txc),
    .tx_frames (tx_frames),
    .tx_aborts (tx_aborts)
  );

  always #5 clk156 = ~clk156;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] mkBeat(input int base);
    logic [63:0] b;
    for (int j = 0; j < 8; j++) b[8*j +: 8] = 8'(base + j);
    return b;
  endfunction

  // Present one cycle of stimulus; returns at the following falling edge.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l);
    s_valid = v;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    @(negedge clk156);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    repeat (2) @(negedge clk156);
    assertCount++; if (xgmii_txd !== IDLE_W) begin failCount++; $display("[TB] FAIL reset_txd: got %h want %h", xgmii_txd, IDLE_W); end
    assertCount++; if (xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL reset_txc: got %h want ff", xgmii_txc); end
    assertCount++; if (s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready: got %b want 0", s_ready); end
    assertCount++; if (tx_frames !== 32'd0) begin failCount++; $display("[TB] FAIL reset_frames: got %0d want 0", tx_frames); end
    assertCount++; if (tx_aborts !== 16'd0) begin failCount++; $display("[TB] FAIL reset_aborts: got %0d want 0", tx_aborts); end
    sys_rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    assertCount++; if (xgmii_txd !== IDLE_W || s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL idle_hold: got txd %h ready %b want %h 0", xgmii_txd, s_ready, IDLE_W); end
  endtask

  task automatic test_single_frame();
    applyStimulus(1'b1, mkBeat(0), 8'hFF, 1'b0);
    assertCount++; if (xgmii_txd !== START_W || xgmii_txc !== 8'h01) begin failCount++; $display("[TB] FAIL single_start: got %h/%h want %h/01", xgmii_txd, xgmii_txc, START_W); end
    assertCount++; if (s_ready !== 1'b1) begin failCount++; $display("[TB] FAIL single_ready_pre: got %b want 1", s_ready); end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, mkBeat(8 * k), 8'hFF, k == 7);
      assertCount++; if (xgmii_txd !== mkBeat(8 * k) || xgmii_txc !== 8'h00) begin failCount++; $display("[TB] FAIL single_data%0d: got %h/%h want %h/00", k, xgmii_txd, xgmii_txc, mkBeat(8 * k)); end
      assertCount++; if (s_ready !== (k < 7)) begin failCount++; $display("[TB] FAIL single_ready%0d: got %b want %b", k, s_ready, k < 7); end
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    expFrames++;
    assertCount++; if (xgmii_txd !== TERM_W || xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL single_term: got %h/%h want %h/ff", xgmii_txd, xgmii_txc, TERM_W); end
    assertCount++; if (tx_frames !== 32'(expFrames)) begin failCount++; $display("[TB] FAIL single_frames: got %0d want %0d", tx_frames, expFrames); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    assertCount++; if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL single_ifg: got %h/%h want %h/ff", xgmii_txd, xgmii_txc, IDLE_W); end
  endtask

  task automatic test_partial_last();
    applyStimulus(1'b1, mkBeat(0), 8'hFF, 1'b0);
    assertCount++; if (xgmii_txd !== START_W) begin failCount++; $display("[TB] FAIL partial_start: got %h want %h", xgmii_txd, START_W); end
    applyStimulus(1'b1, mkBeat(0), 8'hFF, 1'b0);
    assertCount++; if (xgmii_txd !== mkBeat(0)) begin failCount++; $display("[TB] FAIL partial_data0: got %h want %h", xgmii_txd, mkBeat(0)); end
    applyStimulus(1'b1, mkBeat(8), 8'h0F, 1'b1);
    expFrames++;
    assertCount++; if (xgmii_txd !== 64'h070707FD0B0A0908 || xgmii_txc !== 8'hF0) begin failCount++; $display("[TB] FAIL partial_term: got %h/%h want 070707fd0b0a0908/f0", xgmii_txd, xgmii_txc); end
    assertCount++; if (tx_frames !== 32'(expFrames) || s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL partial_frames: got %0d ready %b want %0d 0", tx_frames, s_ready, expFrames); end
    // Next frame already waiting: r=3 so two idle words must precede its /S/.
    applyStimulus(1'b1, mkBeat(64), 8'hFF, 1'b1);
    assertCount++; if (xgmii_txd !== IDLE_W || s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL partial_ifg1: got %h ready %b want %h 0", xgmii_txd, s_ready, IDLE_W); end
    applyStimulus(1'b1, mkBeat(64), 8'hFF, 1'b1);
    assertCount++; if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL partial_ifg2: got %h/%h want %h/ff", xgmii_txd, xgmii_txc, IDLE_W); end
    applyStimulus(1'b1, mkBeat(64), 8'hFF, 1'b1);
    assertCount++; if (xgmii_txd !== START_W || xgmii_txc !== 8'h01) begin failCount++; $display("[TB] FAIL partial_restart: got %h/%h want %h/01", xgmii_txd, xgmii_txc, START_W); end
    applyStimulus(1'b1, mkBeat(64), 8'hFF, 1'b1);
    assertCount++; if (xgmii_txd !== mkBeat(64) || xgmii_txc !== 8'h00) begin failCount++; $display("[TB] FAIL partial_full_last: got %h/%h want %h/00", xgmii_txd, xgmii_txc, mkBeat(64)); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    expFrames++;
    assertCount++; if (xgmii_txd !== TERM_W || tx_frames !== 32'(expFrames)) begin failCount++; $display("[TB] FAIL partial_spill_term: got %h frames %0d want %h %0d", xgmii_txd, tx_frames, TERM_W, expFrames); end
    applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, mkBeat(128), 8'hFF, 1'b1);
    assertCount++; if (xgmii_txd !== START_W) begin failCount++; $display("[TB] FAIL b2b_start1: got %h want %h", xgmii_txd, START_W); end
    applyStimulus(1'b1, mkBeat(128), 8'hFF, 1'b1);
    assertCount++; if (xgmii_txd !== mkBeat(128) || xgmii_txc !== 8'h00) begin failCount++; $display("[TB] FAIL b2b_data1: got %h/%h want %h/00", xgmii_txd, xgmii_txc, mkBeat(128)); end
    applyStimulus(1'b1, mkBeat(144), 8'h03, 1'b1);
    expFrames++;
    assertCount++; if (xgmii_txd !== TERM_W || tx_frames !== 32'(expFrames)) begin failCount++; $display("[TB] FAIL b2b_term1: got %h frames %0d want %h %0d", xgmii_txd, tx_frames, TERM_W, expFrames); end
    applyStimulus(1'b1, mkBeat(144), 8'h03, 1'b1);
    assertCount++; if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL b2b_gap: got %h/%h want %h/ff", xgmii_txd, xgmii_txc, IDLE_W); end
    applyStimulus(1'b1, mkBeat(144), 8'h03, 1'b1);
    assertCount++; if (xgmii_txd !== START_W || xgmii_txc !== 8'h01) begin failCount++; $display("[TB] FAIL b2b_start2: got %h/%h want %h/01", xgmii_txd, xgmii_txc, START_W); end
    applyStimulus(1'b1, mkBeat(144), 8'h03, 1'b1);
    expFrames++;
    assertCount++; if (xgmii_txd !== 64'h0707070707FD9190 || xgmii_txc !== 8'hFC) begin failCount++; $display("[TB] FAIL b2b_term2: got %h/%h want 0707070707fd9190/fc", xgmii_txd, xgmii_txc); end
    assertCount++; if (tx_frames !== 32'(expFrames)) begin failCount++; $display("[TB] FAIL b2b_frames: got %0d want %0d", tx_frames, expFrames); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    assertCount++; if (xgmii_txd !== IDLE_W || s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_idle: got %h ready %b want %h 0", xgmii_txd, s_ready, IDLE_W); end
  endtask

  task automatic test_underrun();
    applyStimulus(1'b1, mkBeat(0), 8'hFF, 1'b0);
    assertCount++; if (xgmii_txd !== START_W) begin failCount++; $display("[TB] FAIL under_start: got %h want %h", xgmii_txd, START_W); end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, mkBeat(8 * k), 8'hFF, 1'b0);
      assertCount++; if (xgmii_txd !== mkBeat(8 * k)) begin failCount++; $display("[TB] FAIL under_data%0d: got %h want %h", k, xgmii_txd, mkBeat(8 * k)); end
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    assertCount++; if (xgmii_txd !== ERR_W || xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL under_err: got %h/%h want %h/ff", xgmii_txd, xgmii_txc, ERR_W); end
    applyStimulus(1'b1, mkBeat(24), 8'hFF, 1'b0);
    expAborts++;
    assertCount++; if (xgmii_txd !== TERM_W || xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL under_term: got %h/%h want %h/ff", xgmii_txd, xgmii_txc, TERM_W); end
    assertCount++; if (tx_aborts !== 16'(expAborts) || s_ready !== 1'b1) begin failCount++; $display("[TB] FAIL under_aborts: got %0d ready %b want %0d 1", tx_aborts, s_ready, expAborts); end
    for (int k = 3; k < 6; k++) begin
      applyStimulus(1'b1, mkBeat(8 * k), 8'hFF, k == 5);
      assertCount++; if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL under_drop%0d: got %h/%h want %h/ff", k, xgmii_txd, xgmii_txc, IDLE_W); end
    end
    assertCount++; if (s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL under_ready_end: got %b want 0", s_ready); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    assertCount++; if (tx_frames !== 32'(expFrames) || tx_aborts !== 16'(expAborts)) begin failCount++; $display("[TB] FAIL under_counts: got %0d/%0d want %0d/%0d", tx_frames, tx_aborts, expFrames, expAborts); end
    applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_bad_keep();
    applyStimulus(1'b1, mkBeat(0), 8'h05, 1'b1);
    assertCount++; if (xgmii_txd !== START_W) begin failCount++; $display("[TB] FAIL badkeep_start: got %h want %h", xgmii_txd, START_W); end
    applyStimulus(1'b1, mkBeat(0), 8'h05, 1'b1);
    assertCount++; if (xgmii_txd !== ERR_W || s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL badkeep_err: got %h ready %b want %h 0", xgmii_txd, s_ready, ERR_W); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    expAborts++;
    assertCount++; if (xgmii_txd !== TERM_W || tx_aborts !== 16'(expAborts)) begin failCount++; $display("[TB] FAIL badkeep_term: got %h aborts %0d want %h %0d", xgmii_txd, tx_aborts, TERM_W, expAborts); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    assertCount++; if (xgmii_txd !== IDLE_W || s_ready !== 1'b0 || tx_frames !== 32'(expFrames)) begin failCount++; $display("[TB] FAIL badkeep_after: got %h ready %b frames %0d want %h 0 %0d", xgmii_txd, s_ready, tx_frames, IDLE_W, expFrames); end
  endtask

`ifdef XGMII_TX_FCS_EN
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic test_fcs();
    logic [31:0] c, refFcs, gotFcs;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) c = crcByte(c, 8'(i));
    refFcs = ~c;
    applyStimulus(1'b1, mkBeat(0), 8'hFF, 1'b0);
    assertCount++; if (xgmii_txd !== START_W) begin failCount++; $display("[TB] FAIL fcs_start: got %h want %h", xgmii_txd, START_W); end
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, mkBeat(8 * k), 8'hFF, 1'b0);
      assertCount++; if (xgmii_txd !== mkBeat(8 * k) || xgmii_txc !== 8'h00) begin failCount++; $display("[TB] FAIL fcs_data%0d: got %h/%h want %h/00", k, xgmii_txd, xgmii_txc, mkBeat(8 * k)); end
    end
    applyStimulus(1'b1, mkBeat(56), 8'h0F, 1'b1);
    gotFcs = xgmii_txd[63:32];
    assertCount++; if (xgmii_txd[31:0] !== 32'h3B3A3938 || xgmii_txc !== 8'h00) begin failCount++; $display("[TB] FAIL fcs_lastdata: got %h/%h want 3b3a3938/00", xgmii_txd[31:0], xgmii_txc); end
    assertCount++; if (gotFcs !== refFcs) begin failCount++; $display("[TB] FAIL fcs_value: got %h want %h", gotFcs, refFcs); end
    for (int i = 0; i < 4; i++) c = crcByte(c, gotFcs[8*i +: 8]);
    assertCount++; if (c !== 32'hDEBB20E3) begin failCount++; $display("[TB] FAIL fcs_residue: got %h want debb20e3", c); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    expFrames++;
    assertCount++; if (xgmii_txd !== TERM_W || xgmii_txc !== 8'hFF || tx_frames !== 32'(expFrames)) begin failCount++; $display("[TB] FAIL fcs_term: got %h/%h frames %0d want %h/ff %0d", xgmii_txd, xgmii_txc, tx_frames, TERM_W, expFrames); end
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
  endtask
`endif

  task automatic test_async_reset();
    applyStimulus(1'b1, mkBeat(0), 8'hFF, 1'b0);
    applyStimulus(1'b1, mkBeat(0), 8'hFF, 1'b0);
    applyStimulus(1'b1, mkBeat(8), 8'hFF, 1'b0);
    assertCount++; if (xgmii_txd !== mkBeat(8) || s_ready !== 1'b1) begin failCount++; $display("[TB] FAIL arst_middata: got %h ready %b want %h 1", xgmii_txd, s_ready, mkBeat(8)); end
    #2;
    sys_rst_n = 1'b0;
    s_valid   = 1'b0;
    #1;
    assertCount++; if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF) begin failCount++; $display("[TB] FAIL arst_outputs: got %h/%h want %h/ff", xgmii_txd, xgmii_txc, IDLE_W); end
    assertCount++; if (s_ready !== 1'b0 || tx_frames !== 32'd0 || tx_aborts !== 16'd0) begin failCount++; $display("[TB] FAIL arst_counters: got ready %b frames %0d aborts %0d want 0 0 0", s_ready, tx_frames, tx_aborts); end
    @(negedge clk156);
    sys_rst_n = 1'b1;
    expFrames = 0;
    expAborts = 0;
    applyStimulus(1'b1, mkBeat(32), 8'h0F, 1'b1);
    assertCount++; if (xgmii_txd !== START_W || xgmii_txc !== 8'h01) begin failCount++; $display("[TB] FAIL arst_start: got %h/%h want %h/01", xgmii_txd, xgmii_txc, START_W); end
    applyStimulus(1'b1, mkBeat(32), 8'h0F, 1'b1);
    expFrames++;
`ifdef XGMII_TX_FCS_EN
    applyStimulus(1'b0, '0, '0, 1'b0);
`endif
    assertCount++; if (tx_frames !== 32'(expFrames) || tx_aborts !== 16'(expAborts)) begin failCount++; $display("[TB] FAIL arst_frames: got %0d/%0d want %0d/%0d", tx_frames, tx_aborts, expFrames, expAborts); end
`ifndef XGMII_TX_FCS_EN
    assertCount++; if (xgmii_txd !== 64'h070707FD23222120 || xgmii_txc !== 8'hF0) begin failCount++; $display("[TB] FAIL arst_term: got %h/%h want 070707fd23222120/f0", xgmii_txd, xgmii_txc); end
`endif
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    assertCount++; if (xgmii_txd !== IDLE_W || s_ready !== 1'b0) begin failCount++; $display("[TB] FAIL arst_final_idle: got %h ready %b want %h 0", xgmii_txd, s_ready, IDLE_W); end
  endtask

  initial begin
    test_reset();
`ifdef XGMII_TX_FCS_EN
    test_fcs();
    test_underrun();
    test_bad_keep();
`else
    test_single_frame();
    test_partial_last();
    test_back_to_back();
    test_underrun();
    test_bad_keep();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/xgmii_tx_encoder.md
# xgmii_tx_encoder

Converts a 64-bit byte stream (valid/ready, keep, last) into XGMII transmit words: it adds the start/preamble word, a terminate character and the minimum inter-frame gap. It is the transmit counterpart of the XGMII receive path and sits between an l2switch egress port and a `network_path` instance (`xgmii_txd`/`xgmii_txc`) in the clk156 domain. It can also compute and append the Ethernet FCS.

## Interface
Parameters:
- none

Ports:
- `clk156` in 1 — 156.25 MHz XGMII clock; the only clock.
- `sys_rst_n` in 1 — reset, asynchronous and active-low.
- `s_data` in 64 — frame bytes; byte 0 in [7:0] goes first on the wire.
- `s_keep` in 8 — valid byte mask; must be 8'hFF on non-last beats and contiguous from bit 0 on the last beat.
- `s_last` in 1 — marks the final beat of a frame.
- `s_valid` in 1 — beat valid.
- `s_ready` out 1 — the beat is accepted when `s_valid && s_ready`.
- `xgmii_txd` out 64 — XGMII transmit data to the PHY.
- `xgmii_txc` out 8 — XGMII control flags, one per lane.
- `tx_frames` out 32 — count of frames that completed normally; wraps.
- `tx_aborts` out 16 — count of aborted frames (underrun or bad keep); wraps.

## Operation
- States: IDLE, PRE, DATA, FCS, TERM, IFG.
- IDLE:
  - outputs idle: txd 64'h0707070707070707, txc 8'hFF; `s_ready`=0.
  - `s_valid`=1 → PRE.
- PRE:
  - emits one start word: txd 64'hD5555555555555FB, txc 8'h01 (/S/ is always in lane 0).
  - `s_ready`=1 → DATA.
- DATA:
  - each accepted beat is emitted on the next cycle with txc=8'h00 for its data lanes.
  - Last beat with n valid bytes (n=1..8): lanes ≥n carry the FCS (if enabled) or /T/ (8'hFD), then 8'h07 idles; txc=1 on every control lane.
  - When /T/ or FCS bytes do not fit in the last word, they spill to the next word (state FCS/TERM).
  - `s_ready` drops the cycle after the last beat is accepted.
- Underrun: `s_valid`=0 in DATA before `s_last`:
  - emit an error word (all lanes 8'hFE, txc 8'hFF), then a terminate word (/T/ in lane 0, rest idle); increment `tx_aborts`.
  - enter a DROP sub-mode: `s_ready`=1 and beats are discarded until one with `s_last`, then IFG.
- Bad keep on the last beat (zero or non-contiguous): treated exactly like an underrun, without a drop phase.
- IFG:
  - r = count of idle lanes after /T/ in the terminate word.
  - Emit 1 full idle word if r≥4, otherwise 2, so the gap is ≥12 bytes. Then IDLE.
- `tx_frames` increments in the cycle the terminate word of a normal frame is emitted.

## Timing
- Reset values:
  - txd 64'h0707070707070707, txc 8'hFF, `s_ready` 0.
  - counters 0; state IDLE.
- All outputs are registered.
- Latency: first `s_valid` in IDLE → start word 1 cycle later; each accepted beat appears on txd 1 cycle after acceptance.
- Back-to-back frames: at least 1 idle word between the terminate word and the next start word; throughput is one beat per cycle during DATA.
- Min frame length is not enforced; padding is upstream's job.
- Asserting `sys_rst_n` low mid-frame forces idle outputs immediately (asynchronously). No /T/ is sent and counters clear.
- Counter increment and wrap on the same cycle: counter goes to 0.

## Configuration
- `XGMII_TX_FCS_EN` defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR) is computed over all data bytes and appended LSB-first after the last byte.
  - A spill adds at most 1 word.
  - The CRC is restarted in PRE.
- Not defined:
  - `s_data` already carries the FCS; /T/ goes directly after byte n−1.
  - No CRC logic is present.

## Test plan
- Single 64-byte frame, 8 full beats, FCS disabled:
  - expect start word, then 8 data words (txc 00), then terminate word txd 64'h07070707070707FD / txc FF.
  - Then 1 idle word; `tx_frames`=1.
- Last beat keep 8'h0F, FCS disabled:
  - terminate in the same word: lane 4=FD, lanes 5–7=07, txc 8'hF0; r=3, so 2 idle words follow.
- `XGMII_TX_FCS_EN`, 60-byte frame of 0x00..0x3B:
  - FCS bytes match the reference CRC.
  - Last beat keep 8'h0F → lanes 4–7 = FCS, txc 8'h00; next word /T/ in lane 0.
- Underrun: drop `s_valid` for 1 cycle after beat 3 of 6:
  - error word FE×8 / FF, then terminate word.
  - Remaining beats are consumed with nothing emitted until `s_last`; `tx_aborts`=1, `tx_frames` unchanged.
- Back-to-back frames with `s_valid` held high:
  - ≥12 idle bytes between /T/ and the next /S/; the next start word is always at lane 0.
- `sys_rst_n` pulsed low mid-DATA:
  - outputs return to idle/FF, `s_ready`=0 and counters 0 asynchronously.
  - The next frame transmits normally.
